// File: rtl/move_packer.sv
// Packs 4-bit solver move codes into a SLOTS-wide move vector for the cube state updater.
// Optional code filtering under MOVE_CHECK_EN; one-cycle issue pulse, holds batch until state_updated.
module move_packer #(
  parameter int          SLOTS = 50,
  parameter logic [3:0]  NOP   = 4'd0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [3:0]                   move_in,
  input  logic                         move_valid,
  input  logic                         move_last,
  input  logic                         state_updated,
  output logic                         move_ready,
  output logic [4*SLOTS-1:0]           moves,
  output logic                         new_moves_ready,
  output logic [$clog2(SLOTS+1)-1:0]   move_count,
  output logic                         bad_move
);

  localparam int CW = $clog2(SLOTS+1);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [4*SLOTS-1:0] moves_q, moves_d;
  logic [CW-1:0]      count_q, count_d;
  logic               xfer;
  logic               code_ok;

  assign xfer = move_valid && (state_q == FILL);

`ifdef MOVE_CHECK_EN
  logic bad_q, bad_d;

  assign code_ok  = (move_in >= 4'd2) && (move_in <= 4'd13);
  assign bad_move = bad_q;

  always_comb begin
    bad_d = bad_q;
    if (xfer && !code_ok) bad_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) bad_q <= 1'b0;
    else       bad_q <= bad_d;
  end
`else
  assign code_ok  = 1'b1;
  assign bad_move = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    moves_d = moves_q;
    count_d = count_q;
    case (state_q)
      FILL: begin
        if (xfer) begin
          // Slot index equals the current count; the count never passes SLOTS.
          if (code_ok && (count_q < CW'(SLOTS))) begin
            for (int k = 0; k < SLOTS; k++) begin
              if (count_q == CW'(k)) moves_d[4*(SLOTS-1-k) +: 4] = move_in;
            end
            count_d = count_q + 1'b1;
          end
          if ((move_last || (count_d == CW'(SLOTS))) && (count_d != '0))
            state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (state_updated) begin
          moves_d = {SLOTS{NOP}};
          count_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      moves_q <= {SLOTS{NOP}};
      count_q <= '0;
    end else begin
      state_q <= state_d;
      moves_q <= moves_d;
      count_q <= count_d;
    end
  end

  assign move_ready      = (state_q == FILL);
  assign new_moves_ready = (state_q == ISSUE);
  assign moves           = moves_q;
  assign move_count      = count_q;

endmodule

// File: tb/tb_move_packer.sv
// Scoreboard bench for move_packer: expected batches queued at stimulus time, checked on each issue pulse.
module tb_move_packer;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   move_in;
  logic         move_valid;
  logic         move_last;
  logic         state_updated;
  logic         move_ready;
  logic [199:0] moves;
  logic         new_moves_ready;
  logic [5:0]   move_count;
  logic         bad_move;

  typedef struct {
    logic [199:0] mv;
    logic [5:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  move_packer dut (
    .clock(clock), .reset(reset), .move_in(move_in), .move_valid(move_valid),
    .move_last(move_last), .state_updated(state_updated), .move_ready(move_ready),
    .moves(moves), .new_moves_ready(new_moves_ready), .move_count(move_count),
    .bad_move(bad_move)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [199:0] set_slot(input logic [199:0] v, input int k, input logic [3:0] c);
    logic [199:0] r;
    r = v;
    r[199-4*k -: 4] = c;
    return r;
  endfunction

  // Monitor: every issue pulse must match the oldest queued batch.
  always @(negedge clock) begin
    if (!reset && new_moves_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got pulse with moves %h expected none", moves);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_moves", moves, e.mv);
        chk("pulse_count", 200'(move_count), 200'(e.cnt));
      end
    end
  end

  task automatic send(input logic [3:0] code, input logic last);
    move_in    = code;
    move_last  = last;
    move_valid = 1'b1;
    @(posedge clock); #1;
    move_valid = 1'b0;
    move_last  = 1'b0;
  endtask

  task automatic ack();
    state_updated = 1'b1;
    @(posedge clock); #1;
    state_updated = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 200'(move_ready), 200'(1));
    chk({tag, "_count"}, 200'(move_count), 200'(0));
    chk({tag, "_moves"}, moves, 200'(0));
    chk({tag, "_pulse"}, 200'(new_moves_ready), 200'(0));
  endtask

  initial begin
    exp_t         e;
    logic [199:0] all_c;
    reset = 1'b1; move_in = 4'd0; move_valid = 1'b0; move_last = 1'b0; state_updated = 1'b0;
    #12;
    check_idle("reset");
    chk("reset_bad", 200'(bad_move), 200'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    // R, U, Fi with last on Fi
    e.mv = '0; e.mv[199 -: 12] = 12'h247; e.cnt = 6'd3;
    exp_q.push_back(e);
    send(4'd2, 1'b0);
    send(4'd4, 1'b0);
    send(4'd7, 1'b1);
    chk("b1_pulse_n1", 200'(new_moves_ready), 200'(1));
    chk("b1_ready_n1", 200'(move_ready), 200'(0));
    @(posedge clock); #1;
    chk("b1_pulse_gone", 200'(new_moves_ready), 200'(0));
    chk("b1_count_hold", 200'(move_count), 200'(3));
    state_updated = 1'b1;
    @(posedge clock); #1;
    state_updated = 1'b0;
    check_idle("b1_ack");

    // 50 x D auto-close, then Bi driven through WAIT
    all_c = {50{4'hC}};
    e.mv = all_c; e.cnt = 6'd50;
    exp_q.push_back(e);
    for (int i = 0; i < 50; i++) send(4'd12, 1'b0);
    chk("b2_ready_after_close", 200'(move_ready), 200'(0));
    move_in = 4'd11; move_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
    end
    move_valid = 1'b0;
    chk("b2_moves_held", moves, all_c);
    chk("b2_count_held", 200'(move_count), 200'(50));
    ack();
    check_idle("b2_ack");

    // L, 4'hF, B (last)
`ifdef MOVE_CHECK_EN
    e.mv = set_slot(set_slot('0, 0, 4'd8), 1, 4'd10); e.cnt = 6'd2;
`else
    e.mv = set_slot(set_slot(set_slot('0, 0, 4'd8), 1, 4'hF), 2, 4'd10); e.cnt = 6'd3;
`endif
    exp_q.push_back(e);
    send(4'd8, 1'b0);
    send(4'hF, 1'b0);
    send(4'd10, 1'b1);
    @(posedge clock); #1;
`ifdef MOVE_CHECK_EN
    chk("b3_bad", 200'(bad_move), 200'(1));
`else
    chk("b3_bad", 200'(bad_move), 200'(0));
`endif
    ack();

    // Asynchronous reset after 20 moves
    for (int i = 0; i < 20; i++) send(4'd2, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_idle("mid_reset");
    chk("mid_reset_bad", 200'(bad_move), 200'(0));
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("post_reset_count", 200'(move_count), 200'(0));
    e.mv = set_slot('0, 0, 4'd13); e.cnt = 6'd1;
    exp_q.push_back(e);
    send(4'd13, 1'b1);
    chk("b4_pulse", 200'(new_moves_ready), 200'(1));
    @(posedge clock); #1;
    ack();

`ifdef MOVE_CHECK_EN
    // Dropped code carrying last with an empty batch
    send(4'd0, 1'b1);
    chk("empty_close_pulse", 200'(new_moves_ready), 200'(0));
    chk("empty_close_ready", 200'(move_ready), 200'(1));
    chk("empty_close_count", 200'(move_count), 200'(0));
`endif

    repeat (4) @(posedge clock);
    #1;
    chk("scoreboard_drained", 200'(exp_q.size()), 200'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
